// File: rtl/rv_ctrl_pkg.sv
// Shared control definitions for the RV32I multi-cycle core.
//   seq_state_e    : sequencer state encoding
//   PC_SRC_*       : PC mux select codes (identical to the decoder's PCsel codes)
//   is_wait_state  : states in which the shared wait timer runs
package rv_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_WAIT_ID,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT,
    ST_ERROR
  } seq_state_e;

  localparam logic [1:0] PC_SRC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_ALU    = 2'd2;

  function automatic logic is_wait_state(input seq_state_e s);
    return (s == ST_FETCH) || (s == ST_WAIT_ID) || (s == ST_MEM);
  endfunction

endpackage

// File: rtl/cpu_sequencer_wait_timer.sv
// Shared wait-state timer.
//   clk, rst_n : clock, async active-low reset
//   clear_i    : restart the count (asserted on every state change)
//   enable_i   : count this cycle (sequencer is in a wait state)
//   expired_o  : the current cycle is the WAIT_TIMEOUT-th waiting cycle
module wait_timer #(
  parameter int unsigned WAIT_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned W = $clog2(WAIT_TIMEOUT + 1);

  // Holds the number of waiting cycles already completed in the current state.
  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (enable_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired_o = enable_i && (cnt_q == W'(WAIT_TIMEOUT - 1));

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer for the RV32I core.
// Steps each instruction through FETCH, DECODE, WAIT_ID, EXEC, [MEM], WB and
// drives the per-stage enable strobes. All outputs are registered.
//   start                     : leave IDLE
//   imem_ready / dmem_ready   : IMEM / DMEM handshakes
//   id_comp + decoder fields  : decoder result, latched in WAIT_ID
//   branch_taken              : ALU compare result for conditional branches
//   fetch, decode, alu_en,
//   mem_req, reg_we, pc_we    : stage strobes
//   pc_src                    : PC mux select (valid with pc_we)
//   halted / error            : sticky stop indications
//   retired                   : wrapping retired-instruction count
module cpu_sequencer
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_TIMEOUT = 15,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             imem_ready,
  input  logic             id_comp,
  input  logic             halt_in,
  input  logic             branch,
  input  logic [1:0]       pcsel_in,
  input  logic             regwrite_in,
  input  logic             memread_in,
  input  logic             memwrite_in,
  input  logic             branch_taken,
  input  logic             dmem_ready,
  output logic             fetch,
  output logic             decode,
  output logic             alu_en,
  output logic             mem_req,
  output logic             reg_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             halted,
  output logic             error,
  output logic [CNT_W-1:0] retired
);

  seq_state_e state_q, state_d;

  logic       branch_q;
  logic [1:0] pcsel_q;
  logic       regwrite_q;
  logic       mem_q;
  logic [1:0] pc_src_d;

  logic fetch_q, decode_q, alu_en_q, mem_req_q, reg_we_q, pc_we_q;
  logic halted_q, error_q;
  logic [1:0]       pc_src_q;
  logic [CNT_W-1:0] retired_q;

  logic timer_expired;

  // Clearing on any state change means every wait state is entered with a zero count.
  wait_timer #(
    .WAIT_TIMEOUT(WAIT_TIMEOUT)
  ) u_wait_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (state_d != state_q),
    .enable_i  (is_wait_state(state_q)),
    .expired_o (timer_expired)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (start) state_d = ST_FETCH;
      ST_FETCH: begin
        if (imem_ready)         state_d = ST_DECODE;
        else if (timer_expired) state_d = ST_ERROR;
      end
      ST_DECODE:  state_d = ST_WAIT_ID;
      ST_WAIT_ID: begin
        if (id_comp)            state_d = halt_in ? ST_HALT : ST_EXEC;
        else if (timer_expired) state_d = ST_ERROR;
      end
      ST_EXEC:    state_d = mem_q ? ST_MEM : ST_WB;
      ST_MEM: begin
        if (dmem_ready)         state_d = ST_WB;
        else if (timer_expired) state_d = ST_ERROR;
      end
      ST_WB:      state_d = ST_FETCH;
      ST_HALT:    state_d = ST_HALT;
      ST_ERROR:   state_d = ST_ERROR;
      default:    state_d = ST_IDLE;
    endcase
  end

  // branch_taken is sampled on the edge into WB so the registered pc_src
  // is stable for the whole WB cycle alongside pc_we.
  always_comb begin
    pc_src_d = PC_SRC_PLUS4;
    if (pcsel_q == PC_SRC_ALU) begin
      pc_src_d = PC_SRC_ALU;
    end else if (pcsel_q == PC_SRC_BRANCH && branch_q && branch_taken) begin
      pc_src_d = PC_SRC_BRANCH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      branch_q   <= 1'b0;
      pcsel_q    <= '0;
      regwrite_q <= 1'b0;
      mem_q      <= 1'b0;
      fetch_q    <= 1'b0;
      decode_q   <= 1'b0;
      alu_en_q   <= 1'b0;
      mem_req_q  <= 1'b0;
      reg_we_q   <= 1'b0;
      pc_we_q    <= 1'b0;
      pc_src_q   <= '0;
      halted_q   <= 1'b0;
      error_q    <= 1'b0;
      retired_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_WAIT_ID && id_comp) begin
        branch_q   <= branch;
        pcsel_q    <= pcsel_in;
        regwrite_q <= regwrite_in;
        // A combined read+write is a single DMEM access.
        mem_q      <= memread_in | memwrite_in;
      end
      fetch_q   <= (state_d == ST_FETCH);
      decode_q  <= (state_d == ST_DECODE);
      alu_en_q  <= (state_d == ST_EXEC);
      mem_req_q <= (state_d == ST_MEM);
      reg_we_q  <= (state_d == ST_WB) && regwrite_q;
      pc_we_q   <= (state_d == ST_WB);
      pc_src_q  <= (state_d == ST_WB) ? pc_src_d : PC_SRC_PLUS4;
      halted_q  <= (state_d == ST_HALT);
      error_q   <= (state_d == ST_ERROR);
      if (state_d == ST_WB) begin
        retired_q <= retired_q + CNT_W'(1);
      end
    end
  end

  assign fetch   = fetch_q;
  assign decode  = decode_q;
  assign alu_en  = alu_en_q;
  assign mem_req = mem_req_q;
  assign reg_we  = reg_we_q;
  assign pc_we   = pc_we_q;
  assign pc_src  = pc_src_q;
  assign halted  = halted_q;
  assign error   = error_q;
  assign retired = retired_q;

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Multi-cycle control sequencer for the RV32I core.
- Acts as the initiator of the decode handshake: it issues the `decode` strobe to the instruction decoder and consumes its `id_comp`, `halt`, `branch`, `PCsel`, `regwrite`, `memread` and `memwrite` outputs.
- Steps each instruction through FETCH, DECODE, EXEC, MEM and WB.
- Drives the enable strobes for IMEM, ALU, DMEM, the register file and the PC.

Parameters:
- WAIT_TIMEOUT, 15: maximum cycles spent in any wait state (IMEM, decoder, DMEM) before entering ERROR.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin execution from IDLE.
- imem_ready  in  1  instruction word valid on IMEM output.
- id_comp  in  1  decoder done; decoder control outputs are valid this cycle.
- halt_in  in  1  decoder halt (ECALL/EBREAK).
- branch  in  1  decoder branch flag.
- pcsel_in  in  2  decoder PCsel (0 = PC+4, 1 = branch target, 2 = ALU out).
- regwrite_in  in  1  decoder regwrite.
- memread_in  in  1  decoder memread.
- memwrite_in  in  1  decoder memwrite.
- branch_taken  in  1  ALU compare result; sampled in WB.
- dmem_ready  in  1  DMEM access complete.
- fetch  out  1  IMEM read request.
- decode  out  1  single-cycle decode strobe to the decoder.
- alu_en  out  1  ALU/operand latch enable.
- mem_req  out  1  DMEM request.
- reg_we  out  1  register-file write enable.
- pc_we  out  1  PC update enable.
- pc_src  out  2  PC mux select.
- halted  out  1  core stopped by ECALL/EBREAK.
- error  out  1  wait timeout occurred.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- Moore FSM; every output is registered.
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All strobes, pc_src, halted, error, retired and the wait counter clear to 0 immediately.
  - This applies mid-instruction too; no partial write completes.
- States: IDLE, FETCH, DECODE, WAIT_ID, EXEC, MEM, WB, HALT, ERROR.
- IDLE:
  - All outputs 0.
  - start=1 goes to FETCH.
- FETCH:
  - fetch=1.
  - imem_ready=1 goes to DECODE. This includes the first cycle in FETCH, so the minimum stay is 1 cycle.
- DECODE:
  - decode=1 for exactly one cycle.
  - Always goes to WAIT_ID.
- WAIT_ID:
  - decode=0; wait for id_comp=1 (the decoder asserts it one cycle after decode).
  - On id_comp, latch branch, pcsel_in, regwrite_in, memread_in and memwrite_in.
  - If halt_in=1, go to HALT. Otherwise go to EXEC.
  - id_comp arriving in any other state is ignored.
- EXEC:
  - alu_en=1 for one cycle.
  - If the latched memread or memwrite is set, go to MEM. Otherwise go to WB.
- MEM:
  - mem_req=1 until dmem_ready.
  - dmem_ready goes to WB.
  - If memread and memwrite are both latched, treat the access as a single access.
- WB, one cycle:
  - reg_we = latched regwrite; pc_we=1.
  - pc_src rules:
    - 2 when latched PCsel=2.
    - 1 when latched PCsel=1 and branch=1 and branch_taken=1.
    - 0 otherwise.
  - retired increments and wraps at 2^CNT_W-1 → 0.
  - Go to FETCH.
- HALT:
  - halted=1; all strobes 0.
  - pc_we=0, so the PC stays on the halting instruction.
  - Sticky until reset; start is ignored.
- Wait timeout:
  - One shared wait counter clears on entry to FETCH, WAIT_ID and MEM, and increments each cycle spent waiting there.
  - Reaching WAIT_TIMEOUT without the awaited signal goes to ERROR.
- ERROR:
  - error=1; all strobes 0.
  - Sticky until reset.
- Latency:
  - Non-memory instruction with zero-wait IMEM: 5 cycles, FETCH to WB inclusive.
  - Load/store: 6 + DMEM wait cycles.
- Simultaneous inputs:
  - start while not in IDLE has no effect.
  - imem_ready or dmem_ready outside its wait state is ignored.

Decomposition:
- Shared package rv_ctrl_pkg holds:
  - The state encoding enum.
  - PC_SRC_PLUS4=0, PC_SRC_BRANCH=1, PC_SRC_ALU=2. These match the decoder's PCsel codes.
- Sub-module wait_timer:
  - Inputs: clear, enable.
  - Output: expired, at WAIT_TIMEOUT.
  - Parameterised by WAIT_TIMEOUT and instantiated once.

Test Plan:
1. ADDI, imem_ready tied 1, id_comp one cycle after decode, regwrite=1, pcsel=0 → fetch, decode, alu_en, reg_we+pc_we each high exactly one cycle in that order; pc_src=0; retired=1 after 5 cycles.
2. LW, dmem_ready after 3 cycles → mem_req high 3 cycles; reg_we=1 in WB; total 8 cycles.
3. BEQ pcsel=1, branch=1: branch_taken=1 → pc_src=1, reg_we=0; repeat with branch_taken=0 → pc_src=0.
4. ECALL, halt_in=1 with id_comp → HALT; halted=1 permanently, no pc_we or reg_we; start pulses ignored; rst_n low clears halted.
5. DMEM never ready → error=1 after 15 MEM cycles; all strobes 0 thereafter.
6. rst_n low for 1 cycle during MEM of SW → mem_req drops asynchronously, state IDLE, retired=0; start re-runs cleanly from FETCH.
